// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: owns the ROB enqueue/dequeue pointers and the
// occupancy counter, grants up to two in-order dispatch slots per cycle,
// frees slots on commit and rewinds the enqueue pointer on flush.
module rob_alloc_ctrl #(
  parameter int ROB_SIZE     = 64,
  parameter int ROB_SIZE_LOG = 6
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    instr0_valid,
  input  logic                    instr1_valid,
  output logic                    instr0_ready,
  output logic                    instr1_ready,
  input  logic                    issue0_ready,
  input  logic                    issue1_ready,
  output logic                    instr0_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] instr0_robidx,
  output logic                    instr1_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] instr1_robidx,
  input  logic                    commit0_valid,
  input  logic                    commit1_valid,
  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx,
  output logic                    deq_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] deq_robidx,
  output logic [ROB_SIZE_LOG:0]   counter,
  output logic                    full,
  output logic                    empty
);

  // A pointer is {wrap flag, index}. Because ROB_SIZE is a power of two,
  // plain modulo-2*ROB_SIZE arithmetic on the concatenation wraps the index
  // and toggles the flag in one step.
  localparam int PW = ROB_SIZE_LOG + 1;
  localparam logic [PW-1:0] ROB_SIZE_W = PW'(ROB_SIZE);

  typedef logic [PW-1:0] ptr_t;

  ptr_t          enq_ptr;
  ptr_t          deq_ptr;
  logic [PW-1:0] count_q;

  ptr_t          enq_next;
  ptr_t          deq_next;
  logic [PW-1:0] count_next;
  logic [PW-1:0] free;
  logic          fire0;
  logic          fire1;
  logic [1:0]    enq_n;
  logic          commit0_ok;
  logic          commit1_ok;
  logic [1:0]    deq_n;
  ptr_t          flush_ptr;
  ptr_t          instr1_ptr;

  assign flush_ptr  = {flush_robidx_flag, flush_robidx};
  assign instr1_ptr = enq_ptr + PW'(1);

  // Free space comes from the registered counter only, so commits arriving
  // this cycle never open space for allocation in the same cycle.
  assign free = ROB_SIZE_W - count_q;

  // Grants: slot 1 only alongside slot 0 so allocation stays in order;
  // nothing is granted while reset is held or during a flush.
  assign instr0_ready = reset_n & ~flush_valid & issue0_ready & (free >= PW'(1));
  assign instr1_ready = instr0_valid & instr0_ready & issue1_ready & (free >= PW'(2));

  assign fire0 = instr0_valid & instr0_ready;
  assign fire1 = instr1_valid & instr1_ready;
  assign enq_n = {1'b0, fire0} + {1'b0, fire1};

  // Commits retire in order and can never exceed the current occupancy.
  assign commit0_ok = commit0_valid & (count_q >= PW'(1));
  assign commit1_ok = commit0_ok & commit1_valid & (count_q >= PW'(2));
  assign deq_n      = {1'b0, commit0_ok} + {1'b0, commit1_ok};

  // Next-state: advance both pointers normally; on flush rewind enq and
  // recompute occupancy as the distance between the new pointers.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can leave it unassigned and infer a latch.
    deq_next   = deq_ptr + PW'(deq_n);
    enq_next   = enq_ptr + PW'(enq_n);
    count_next = count_q + PW'(enq_n) - PW'(deq_n);
    if (flush_valid) begin
      enq_next   = flush_ptr;
      // Modulo difference of {flag,idx} pointers equals the occupancy for
      // both equal and differing wrap flags.
      count_next = flush_ptr - deq_next;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: all state sits in flops with an asynchronous reset; there is no storage array here that would need to stay unreset.
    if (!reset_n) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      enq_ptr <= enq_next;
      deq_ptr <= deq_next;
      count_q <= count_next;
    end
  end

  assign instr0_robidx_flag = enq_ptr[PW-1];
  assign instr0_robidx      = enq_ptr[PW-2:0];
  assign instr1_robidx_flag = instr1_ptr[PW-1];
  assign instr1_robidx      = instr1_ptr[PW-2:0];
  assign deq_robidx_flag    = deq_ptr[PW-1];
  assign deq_robidx         = deq_ptr[PW-2:0];
  assign counter            = count_q;
  assign full               = (count_q == ROB_SIZE_W);
  assign empty              = (count_q == '0);

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Self-checking bench for rob_alloc_ctrl. A driver issues one stimulus per
// cycle and pushes the expected observation into a scoreboard queue; a
// monitor pops and compares against the DUT outputs.
module tb_rob_alloc_ctrl;

  localparam int N   = 64;
  localparam int LOG = 6;
  localparam int M   = 2 * N; // pointer space {flag, idx}

  logic           clock;
  logic           reset_n;
  logic           instr0_valid, instr1_valid;
  logic           instr0_ready, instr1_ready;
  logic           issue0_ready, issue1_ready;
  logic           instr0_robidx_flag, instr1_robidx_flag;
  logic [LOG-1:0] instr0_robidx, instr1_robidx;
  logic           commit0_valid, commit1_valid;
  logic           flush_valid;
  logic           flush_robidx_flag;
  logic [LOG-1:0] flush_robidx;
  logic           deq_robidx_flag;
  logic [LOG-1:0] deq_robidx;
  logic [LOG:0]   counter;
  logic           full, empty;

  rob_alloc_ctrl #(.ROB_SIZE(N), .ROB_SIZE_LOG(LOG)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .instr0_valid       (instr0_valid),
    .instr1_valid       (instr1_valid),
    .instr0_ready       (instr0_ready),
    .instr1_ready       (instr1_ready),
    .issue0_ready       (issue0_ready),
    .issue1_ready       (issue1_ready),
    .instr0_robidx_flag (instr0_robidx_flag),
    .instr0_robidx      (instr0_robidx),
    .instr1_robidx_flag (instr1_robidx_flag),
    .instr1_robidx      (instr1_robidx),
    .commit0_valid      (commit0_valid),
    .commit1_valid      (commit1_valid),
    .flush_valid        (flush_valid),
    .flush_robidx_flag  (flush_robidx_flag),
    .flush_robidx       (flush_robidx),
    .deq_robidx_flag    (deq_robidx_flag),
    .deq_robidx         (deq_robidx),
    .counter            (counter),
    .full               (full),
    .empty              (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string tag;
    bit    r0, r1;
    int    p0, p1, deq, cnt;
    bit    full, empty;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference model: the ROB as an ordered list of allocated pointer values.
  int rob[$];
  int enq_abs = 0;
  int deq_abs = 0;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t predict(input string tag, input bit v0, input bit i0,
                                   input bit i1, input bit fl);
    exp_t e;
    int   fr;
    fr      = N - rob.size();
    e.tag   = tag;
    e.r0    = !fl && i0 && fr >= 1;
    e.r1    = v0 && e.r0 && i1 && fr >= 2;
    e.p0    = enq_abs;
    e.p1    = (enq_abs + 1) % M;
    e.deq   = deq_abs;
    e.cnt   = rob.size();
    e.full  = (rob.size() == N);
    e.empty = (rob.size() == 0);
    return e;
  endfunction

  // One normal-operation cycle: drive, record expectation, advance model.
  task automatic step(input string tag, input bit v0, input bit v1, input bit i0,
                      input bit i1, input bit c0, input bit c1, input bit fl,
                      input int flp);
    exp_t e;
    int   pos;
    @(negedge clock);
    reset_n           = 1'b1;
    instr0_valid      = v0;
    instr1_valid      = v1;
    issue0_ready      = i0;
    issue1_ready      = i1;
    commit0_valid     = c0;
    commit1_valid     = c1;
    flush_valid       = fl;
    flush_robidx_flag = 1'((flp / N) % 2);
    flush_robidx      = LOG'(flp % N);
    e = predict(tag, v0, i0, i1, fl);
    exp_q.push_back(e);
    // retire oldest entries first
    if (c0 && rob.size() >= 1) begin
      void'(rob.pop_front());
      deq_abs = (deq_abs + 1) % M;
      if (c1 && rob.size() >= 1) begin
        void'(rob.pop_front());
        deq_abs = (deq_abs + 1) % M;
      end
    end
    if (fl) begin
      pos = rob.size();
      for (int k = 0; k < rob.size(); k++)
        if (rob[k] == flp) begin
          pos = k;
          break;
        end
      while (rob.size() > pos) void'(rob.pop_back());
      enq_abs = flp;
    end else begin
      if (v0 && e.r0) begin
        rob.push_back(enq_abs);
        enq_abs = (enq_abs + 1) % M;
      end
      if (v1 && e.r1) begin
        rob.push_back(enq_abs);
        enq_abs = (enq_abs + 1) % M;
      end
    end
  endtask

  // Reset held for one cycle with random valids; everything must read as reset.
  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clock);
    reset_n       = 1'b0;
    instr0_valid  = 1'($urandom);
    instr1_valid  = 1'($urandom);
    issue0_ready  = 1'b1;
    issue1_ready  = 1'b1;
    commit0_valid = 1'b0;
    commit1_valid = 1'b0;
    flush_valid   = 1'b0;
    rob.delete();
    enq_abs = 0;
    deq_abs = 0;
    e = predict(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(e);
  endtask

  // Monitor: compare every scoreboard entry with what the DUT presents.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".instr0_ready"}, int'(instr0_ready), int'(e.r0));
        check({e.tag, ".instr1_ready"}, int'(instr1_ready), int'(e.r1));
        check({e.tag, ".instr0_ptr"}, int'({instr0_robidx_flag, instr0_robidx}), e.p0);
        check({e.tag, ".instr1_ptr"}, int'({instr1_robidx_flag, instr1_robidx}), e.p1);
        check({e.tag, ".deq_ptr"}, int'({deq_robidx_flag, deq_robidx}), e.deq);
        check({e.tag, ".counter"}, int'(counter), e.cnt);
        check({e.tag, ".full"}, int'(full), int'(e.full));
        check({e.tag, ".empty"}, int'(empty), int'(e.empty));
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    bit v0, v1, i0, i1, c0, c1, fl;
    int acc, k, flp, pc;
    reset_n = 1'b0;
    instr0_valid = 0; instr1_valid = 0; issue0_ready = 0; issue1_ready = 0;
    commit0_valid = 0; commit1_valid = 0; flush_valid = 0;
    flush_robidx_flag = 0; flush_robidx = '0;

    do_reset("reset");
    step("first_alloc", 1, 0, 1, 1, 0, 0, 0, 0);
    step("after_first", 0, 0, 1, 1, 0, 0, 0, 0);

    // fill to full, then hold valid with a commit while full
    do_reset("reset_fill");
    for (int c = 0; c < 32; c++) step("fill", 1, 1, 1, 1, 0, 0, 0, 0);
    step("full_commit", 1, 1, 1, 1, 1, 0, 0, 0);
    step("one_free", 1, 1, 1, 1, 0, 0, 0, 0);
    step("refull", 1, 1, 1, 1, 0, 0, 0, 0);

    // wrap: enq {0,63}, deq {0,60}, fire both
    do_reset("reset_wrap");
    for (int c = 0; c < 31; c++) step("wrap_fill", 1, 1, 1, 1, 0, 0, 0, 0);
    step("wrap_fill1", 1, 0, 1, 1, 0, 0, 0, 0);
    for (int c = 0; c < 30; c++) step("wrap_drain", 0, 0, 1, 1, 1, 1, 0, 0);
    step("wrap_both", 1, 1, 1, 1, 0, 0, 0, 0);
    step("wrap_after", 0, 0, 1, 1, 0, 0, 0, 0);

    // slot 1 without slot 0
    step("slot1_only", 0, 1, 1, 1, 0, 0, 0, 0);
    step("slot1_after", 0, 0, 1, 1, 0, 0, 0, 0);

    // flush with concurrent commit: enq {0,20}, deq {0,10} -> flush {0,15}
    do_reset("reset_flush");
    for (int c = 0; c < 10; c++) step("fl_fill", 1, 1, 1, 1, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) step("fl_drain", 0, 0, 1, 1, 1, 1, 0, 0);
    step("flush_commit", 1, 1, 1, 1, 1, 0, 1, 15);
    step("flush_after", 0, 0, 1, 1, 0, 0, 0, 0);

    // ignored commits
    step("commit1_alone", 0, 0, 1, 1, 0, 1, 0, 0);
    do_reset("reset_empty");
    step("commit_empty", 0, 0, 1, 1, 1, 1, 0, 0);
    step("commit_empty_after", 0, 0, 1, 1, 0, 0, 0, 0);

    // randomized traffic with phases of light, medium and heavy commit rates
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset("reset_mid");
      pc = (((c / 200) % 3) == 0) ? 15 : ((((c / 200) % 3) == 1) ? 50 : 90);
      v0 = ($urandom_range(99) < 80);
      v1 = ($urandom_range(99) < 80);
      i0 = ($urandom_range(99) < 85);
      i1 = ($urandom_range(99) < 85);
      c0 = ($urandom_range(99) < pc);
      c1 = ($urandom_range(99) < pc);
      fl = ($urandom_range(99) < 3);
      flp = 0;
      if (fl) begin
        acc = 0;
        if (c0 && rob.size() >= 1) acc = (c1 && rob.size() >= 2) ? 2 : 1;
        k   = $urandom_range(rob.size() - acc);
        flp = (deq_abs + acc + k) % M;
      end
      step("rand", v0, v1, i0, i1, c0, c1, fl, flp);
    end

    @(negedge clock);
    #3;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rob_alloc_ctrl.md
# rob_alloc_ctrl

ROB allocation controller sitting between rename/dispatch and the ROB. Owns the ROB enqueue and dequeue pointers (each an index plus wrap flag) and the occupancy counter. Grants up to two in-order dispatch slots per cycle and hands each granted instruction its ROB index. Frees slots on commit and rolls the enqueue pointer back on flush.

## Interface
Parameters:
- ROB_SIZE, 64, number of ROB entries; must be a power of two
- ROB_SIZE_LOG, 6, log2(ROB_SIZE)

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- instr0_valid  input  1  dispatch slot 0 has an instruction
- instr1_valid  input  1  dispatch slot 1 has an instruction
- instr0_ready  output  1  slot 0 allocation granted
- instr1_ready  output  1  slot 1 allocation granted
- issue0_ready  input  1  issue side can accept slot 0
- issue1_ready  input  1  issue side can accept slot 1
- instr0_robidx_flag  output  1  wrap flag of slot 0 ROB index
- instr0_robidx  output  ROB_SIZE_LOG  slot 0 ROB index
- instr1_robidx_flag  output  1  wrap flag of slot 1 ROB index
- instr1_robidx  output  ROB_SIZE_LOG  slot 1 ROB index
- commit0_valid  input  1  oldest entry retires
- commit1_valid  input  1  second-oldest entry retires
- flush_valid  input  1  squash from the given pointer onward
- flush_robidx_flag  input  1  wrap flag of the oldest squashed entry
- flush_robidx  input  ROB_SIZE_LOG  index of the oldest squashed entry
- deq_robidx_flag  output  1  dequeue pointer wrap flag
- deq_robidx  output  ROB_SIZE_LOG  dequeue pointer index
- counter  output  ROB_SIZE_LOG+1  occupied entries, 0..ROB_SIZE
- full  output  1  counter == ROB_SIZE
- empty  output  1  counter == 0

## Operation
- Pointer is {flag, idx}. Increment by k: idx wraps modulo ROB_SIZE, and flag toggles on each wrap.
- free = ROB_SIZE − counter. This uses the registered counter only; commits this cycle do not create space this cycle.
- instr0_ready = !flush_valid & issue0_ready & (free ≥ 1).
- instr1_ready = instr0_valid & instr0_ready & issue1_ready & (free ≥ 2). Slot 1 is never granted without slot 0, to keep allocation in order.
- fire0 = instr0_valid & instr0_ready. fire1 = instr1_valid & instr1_ready. enq_n = fire0 + fire1.
- instr0_robidx = enq pointer. instr1_robidx = enq pointer + 1. Both are driven regardless of valid.
- Commit count:
  - commit0 is accepted only if counter ≥ 1.
  - commit1 is accepted only if commit0 is accepted and counter ≥ 2.
  - commit1 without commit0 is ignored.
  - deq_n = number accepted.
- Normal cycle:
  - enq += enq_n
  - deq += deq_n
  - counter += enq_n − deq_n
- Flush cycle:
  - enq := {flush_robidx_flag, flush_robidx}
  - deq += deq_n (commits in the same cycle still apply)
  - counter := distance(new enq, new deq)
  - distance = enq_idx − deq_idx if the flags are equal, else ROB_SIZE − deq_idx + enq_idx
  - No allocation occurs in a flush cycle.
- The flush pointer must lie within [new deq, old enq]. Any other value is a caller error and produces undefined results.
- full and empty are decoded from the registered counter.

## Timing
- Reset (asynchronous, reset_n low):
  - enq = deq = {0, 0}
  - counter = 0, empty = 1, full = 0
  - ready outputs are forced to 0 while reset_n is low
- ready outputs and robidx outputs are combinational from registered state and the current-cycle inputs. There is no added latency.
- All state updates at the rising edge of clock. A new counter value is visible the cycle after a fire, commit or flush.
- Handshake: an allocation happens only on valid & ready. valid may drop at any time without side effects.
- Full boundary:
  - counter = ROB_SIZE−1: only slot 0 is grantable.
  - counter = ROB_SIZE: both ready outputs are low, even if a commit arrives that cycle.
- Wrap: enq {0, ROB_SIZE−1} with two fires → instr1 gets {1, 0}, and next enq = {1, 1}.
- A commit and an enqueue in the same cycle net out in counter.
- Reset asserted mid-operation returns all state to reset values immediately.

## Test plan
- Reset, then slot 0 valid with issue0_ready=1 → instr0_ready=1, robidx {0,0}; next cycle counter=1, empty=0.
- Both slots valid for 32 cycles with ROB_SIZE=64 → counter=64, full=1, both ready outputs 0 in cycle 33; one commit → next cycle instr0_ready=1, instr1_ready=0.
- Set enq={0,63} with deq={0,60}, fire both slots → instr1 index {1,0}, enq={1,1}, counter=5.
- Slot 1 valid, slot 0 invalid → instr1_ready=0, counter unchanged.
- State enq={0,20}, deq={0,10}; flush to {0,15} with commit0 in the same cycle → enq={0,15}, deq={0,11}, counter=4, no allocation that cycle.
- Apply commit1 alone, and commit0 with counter=0 → deq and counter unchanged.
